// File: rtl/wait_state_memory.sv
// Processor-bus responder with a word array; optional trace via WAIT_STATE_MEMORY_TRACE_EN.
// Latency: WAIT_STATES cycles of n_wait=0 after the accepting edge, then a one-cycle resp.
// Backpressure: n_wait=0 holds the processor; trans is ignored while waiting.
module wait_state_memory #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic        trans,
  input  logic [1:0]  mas,
  output logic [31:0] rdata,
  output logic        n_wait,
  output logic        resp,
  output logic        abort
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [1:0]  mas_q;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ST_RESP;
      end
      default: begin
        if (trans) begin
          accept    = 1'b1;
          cnt_nxt   = WS;
          state_nxt = (WS != 4'd0) ? ST_WAIT : ST_RESP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live bus is used.
  logic        sel_in;
  logic [31:0] r_addr, r_wdata;
  logic        r_write;
  logic [1:0]  r_mas;
  assign sel_in  = (state != ST_WAIT);
  assign r_addr  = sel_in ? addr  : addr_q;
  assign r_wdata = sel_in ? wdata : wdata_q;
  assign r_write = sel_in ? write : write_q;
  assign r_mas   = sel_in ? mas   : mas_q;

  logic [31:0]           off;
  logic                  in_range, misalign, bad, commit, we;
  logic [ADDR_WIDTH-1:0] idx;
  assign off      = r_addr - BASE_ADDR;
  assign in_range = ({1'b0, off} < SPAN);
  assign idx      = off[ADDR_WIDTH+1:2];
  assign bad      = !in_range || misalign;
  assign commit   = (state_nxt == ST_RESP);
  assign we       = commit && r_write && !bad && n_reset;

  logic [3:0]  be;
  logic [31:0] wlane, mem_word, rmask, rd_val;
  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wlane    = r_wdata;
    rmask    = 32'hFFFF_FFFF;
    case (r_mas)
      2'b00: begin
        be    = 4'b0001 << r_addr[1:0];
        wlane = {4{r_wdata[7:0]}};
        rmask = 32'h0000_00FF;
      end
      2'b01: begin
        misalign = r_addr[0];
        be       = r_addr[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{r_wdata[15:0]}};
        rmask    = 32'h0000_FFFF;
      end
      2'b10:   begin
        misalign = (r_addr[1:0] != 2'b00);
        be       = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  assign mem_word = mem[idx];
  assign rd_val   = (mem_word >> {r_addr[1:0], 3'b000}) & rmask;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      mas_q   <= 2'b00;
      n_wait  <= 1'b1;
      resp    <= 1'b0;
      abort   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= write;
        mas_q   <= mas;
      end
      n_wait <= (state_nxt != ST_WAIT);
      resp   <= commit;
      abort  <= commit && bad;
      if (commit) begin
        if (bad)           rdata <= 32'd0;
        else if (!r_write) rdata <= rd_val;
      end
    end
  end

`ifdef WAIT_STATE_MEMORY_TRACE_EN
  logic [31:0] trace_val;
  always_comb begin
    trace_val = mem_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) trace_val[8*b +: 8] = wlane[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (n_reset && commit)
      $display("%0t wait_state_memory %s mas=%0d addr=%08h data=%08h abort=%0b",
               $time, r_write ? "W" : "R", r_mas, r_addr,
               bad ? 32'd0 : (r_write ? trace_val : rd_val), bad);
  end
`endif

endmodule
